// File: rtl/mem_controller_rr.sv
// Multi-port memory controller: round-robin arbitration onto a byte-packet link,
// posted writes, and up to MAX_OUTSTANDING in-order reads tracked by a tag FIFO.
module mem_controller_rr #(
    parameter int PORT_COUNT      = 2,
    parameter int DATA_WIDTH_BYTE = 4,
    parameter int ADDR_WIDTH_BYTE = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int DATA_WIDTH = 8 * DATA_WIDTH_BYTE,
    localparam int ADDR_WIDTH = 8 * ADDR_WIDTH_BYTE,
    localparam int SEND_BYTE  = 1 + ADDR_WIDTH_BYTE + DATA_WIDTH_BYTE,
    localparam int SEND_W     = 8 * SEND_BYTE,
    localparam int PB         = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    output logic                                 send_flag,
    output logic [SEND_W-1:0]                    send_data,
    output logic [4:0]                           send_length,
    output logic                                 recv_flag,
    input  logic [SEND_W-1:0]                    recv_data,
    input  logic [4:0]                           recv_length,
    input  logic                                 sendable,
    input  logic                                 receivable,
    input  logic [PORT_COUNT*2-1:0]              rw_flag_,
    input  logic [PORT_COUNT*ADDR_WIDTH-1:0]     addr_,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0]     write_data_,
    input  logic [PORT_COUNT*DATA_WIDTH_BYTE-1:0] write_mask_,
    output logic [PORT_COUNT*DATA_WIDTH-1:0]     read_data_,
    output logic [PORT_COUNT-1:0]                busy,
    output logic [PORT_COUNT-1:0]                done,
    output logic [OUT_W-1:0]                     outstanding,
    output logic                                 unexpected_recv
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [PORT_COUNT-1:0]      pend_valid_q, pend_valid_d;
    logic [PORT_COUNT-1:0]      pend_write_q, pend_write_d;
    logic [PORT_COUNT-1:0]      in_flight_q, in_flight_d;
    logic [PORT_COUNT-1:0]      done_q, done_d;
    logic [ADDR_WIDTH-1:0]      pend_addr_q [PORT_COUNT];
    logic [ADDR_WIDTH-1:0]      pend_addr_d [PORT_COUNT];
    logic [DATA_WIDTH-1:0]      pend_data_q [PORT_COUNT];
    logic [DATA_WIDTH-1:0]      pend_data_d [PORT_COUNT];
    logic [DATA_WIDTH_BYTE-1:0] pend_mask_q [PORT_COUNT];
    logic [DATA_WIDTH_BYTE-1:0] pend_mask_d [PORT_COUNT];
    logic [DATA_WIDTH-1:0]      read_data_q [PORT_COUNT];
    logic [DATA_WIDTH-1:0]      read_data_d [PORT_COUNT];
    logic [PB-1:0]              tag_mem_q [MAX_OUTSTANDING];
    logic [PB-1:0]              tag_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]           count_q, count_d;
    logic [PB-1:0]              rr_q, rr_d;
    logic                       send_flag_q, send_flag_d;
    logic [SEND_W-1:0]          send_data_q, send_data_d;
    logic [4:0]                 send_length_q, send_length_d;
    logic                       recv_flag_q, recv_flag_d;
    logic                       unexpected_q, unexpected_d;

    logic [1:0]            rw_w [PORT_COUNT];
    logic [PORT_COUNT-1:0] capture;
    logic [PORT_COUNT-1:0] eligible;
    logic                  fifo_full;
    logic                  grant_valid;
    logic [PB-1:0]         grant_idx;
    int                    best_dist;
    logic                  push, pop;
    logic [PB-1:0]         resp_tag;
    logic [7:0]            hdr;

    // Only the low data bytes of a response and none of its length are meaningful.
    logic unused_inputs;
    assign unused_inputs = ^{recv_length, recv_data[SEND_W-1:DATA_WIDTH]};

    assign fifo_full = (count_q == OUT_W'(MAX_OUTSTANDING));

    for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_port
        assign rw_w[gi]     = rw_flag_[2*gi +: 2];
        assign capture[gi]  = !pend_valid_q[gi] && (rw_w[gi] == 2'd1 || rw_w[gi] == 2'd2);
        assign eligible[gi] = pend_valid_q[gi] && !in_flight_q[gi] && (pend_write_q[gi] || !fifo_full);
        assign read_data_[gi*DATA_WIDTH +: DATA_WIDTH] = read_data_q[gi];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pick the eligible port at the smallest rotational distance after rr_q.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_dist   = PORT_COUNT;
        if (sendable) begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                if (eligible[i] && ((i + 2*PORT_COUNT - 1 - int'(rr_q)) % PORT_COUNT) < best_dist) begin
                    best_dist   = (i + 2*PORT_COUNT - 1 - int'(rr_q)) % PORT_COUNT;
                    grant_valid = 1'b1;
                    grant_idx   = PB'(i);
                end
            end
        end
    end

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_write_d  = pend_write_q;
        in_flight_d   = in_flight_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        pend_mask_d   = pend_mask_q;
        read_data_d   = read_data_q;
        tag_mem_d     = tag_mem_q;
        done_d        = '0;
        rr_d          = rr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        send_flag_d   = 1'b0;
        send_data_d   = send_data_q;
        send_length_d = send_length_q;
        recv_flag_d   = 1'b0;
        unexpected_d  = unexpected_q;
        push          = 1'b0;
        pop           = 1'b0;
        resp_tag      = '0;
        hdr           = '0;

        for (int p = 0; p < PORT_COUNT; p++) begin
            if (capture[p]) begin
                pend_valid_d[p] = 1'b1;
                pend_write_d[p] = (rw_w[p] == 2'd2);
                in_flight_d[p]  = 1'b0;
                pend_addr_d[p]  = addr_[p*ADDR_WIDTH +: ADDR_WIDTH];
                pend_data_d[p]  = write_data_[p*DATA_WIDTH +: DATA_WIDTH];
                pend_mask_d[p]  = write_mask_[p*DATA_WIDTH_BYTE +: DATA_WIDTH_BYTE];
            end
        end

        // The link returns read data in issue order, so the FIFO head owns it.
        if (receivable) begin
            if (count_q != '0) begin
                pop                   = 1'b1;
                resp_tag              = tag_mem_q[rd_ptr_q];
                read_data_d[resp_tag] = recv_data[DATA_WIDTH-1:0];
                done_d[resp_tag]      = 1'b1;
                pend_valid_d[resp_tag] = 1'b0;
                in_flight_d[resp_tag] = 1'b0;
                recv_flag_d           = 1'b1;
                rd_ptr_d              = ptr_inc(rd_ptr_q);
            end else begin
                unexpected_d = 1'b1;
            end
        end

        if (grant_valid) begin
            send_flag_d = 1'b1;
            rr_d        = grant_idx;
            if (pend_write_q[grant_idx]) begin
                hdr                       = 8'h80;
                hdr[DATA_WIDTH_BYTE-1:0]  = pend_mask_q[grant_idx];
                send_data_d   = {hdr, pend_addr_q[grant_idx], pend_data_q[grant_idx]};
                send_length_d = 5'(SEND_BYTE);
                pend_valid_d[grant_idx] = 1'b0;
                done_d[grant_idx]       = 1'b1;
            end else begin
                send_data_d   = SEND_W'({8'h00, pend_addr_q[grant_idx]});
                send_length_d = 5'(ADDR_WIDTH_BYTE + 1);
                in_flight_d[grant_idx] = 1'b1;
                push                   = 1'b1;
                tag_mem_d[wr_ptr_q]    = grant_idx;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
            end
        end

        count_d = count_q + OUT_W'(push) - OUT_W'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_valid_q  <= '0;
            pend_write_q  <= '0;
            in_flight_q   <= '0;
            done_q        <= '0;
            rr_q          <= PB'(PORT_COUNT - 1);
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            send_flag_q   <= 1'b0;
            send_data_q   <= '0;
            send_length_q <= '0;
            recv_flag_q   <= 1'b0;
            unexpected_q  <= 1'b0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                pend_addr_q[p] <= '0;
                pend_data_q[p] <= '0;
                pend_mask_q[p] <= '0;
                read_data_q[p] <= '0;
            end
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                tag_mem_q[t] <= '0;
            end
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_write_q  <= pend_write_d;
            in_flight_q   <= in_flight_d;
            done_q        <= done_d;
            rr_q          <= rr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            send_flag_q   <= send_flag_d;
            send_data_q   <= send_data_d;
            send_length_q <= send_length_d;
            recv_flag_q   <= recv_flag_d;
            unexpected_q  <= unexpected_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            pend_mask_q   <= pend_mask_d;
            read_data_q   <= read_data_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

    assign send_flag       = send_flag_q;
    assign send_data       = send_data_q;
    assign send_length     = send_length_q;
    assign recv_flag       = recv_flag_q;
    assign busy            = pend_valid_q;
    assign done            = done_q;
    assign outstanding     = count_q;
    assign unexpected_recv = unexpected_q;

endmodule

// File: tb/tb_mem_controller_rr.sv
// Bench for mem_controller_rr: transaction-level reference model feeding scoreboard
// queues, directed scenarios followed by randomized traffic.
module tb_mem_controller_rr;
    localparam int P    = 4;
    localparam int DWB  = 4;
    localparam int AWB  = 4;
    localparam int MAXO = 2;
    localparam int DW   = 8 * DWB;
    localparam int AW   = 8 * AWB;
    localparam int SB   = 1 + AWB + DWB;
    localparam int SW   = 8 * SB;
    localparam int OW   = $clog2(MAXO) + 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              send_flag;
    logic [SW-1:0]     send_data;
    logic [4:0]        send_length;
    logic              recv_flag;
    logic [SW-1:0]     recv_data = '0;
    logic [4:0]        recv_length = 5'(DWB);
    logic              sendable = 1'b0;
    logic              receivable = 1'b0;
    logic [P*2-1:0]    rw_flag_ = '0;
    logic [P*AW-1:0]   addr_ = '0;
    logic [P*DW-1:0]   write_data_ = '0;
    logic [P*DWB-1:0]  write_mask_ = '0;
    logic [P*DW-1:0]   read_data_;
    logic [P-1:0]      busy;
    logic [P-1:0]      done;
    logic [OW-1:0]     outstanding;
    logic              unexpected_recv;

    mem_controller_rr #(
        .PORT_COUNT(P), .DATA_WIDTH_BYTE(DWB), .ADDR_WIDTH_BYTE(AWB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .send_flag(send_flag), .send_data(send_data), .send_length(send_length),
        .recv_flag(recv_flag), .recv_data(recv_data), .recv_length(recv_length),
        .sendable(sendable), .receivable(receivable),
        .rw_flag_(rw_flag_), .addr_(addr_), .write_data_(write_data_), .write_mask_(write_mask_),
        .read_data_(read_data_), .busy(busy), .done(done),
        .outstanding(outstanding), .unexpected_recv(unexpected_recv)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            cyc;
        logic [SW-1:0] data;
        logic [4:0]    len;
    } send_t;

    typedef struct {
        logic [P-1:0]    busy;
        logic [OW-1:0]   outst;
        logic            unexp;
        logic [P-1:0]    done;
        logic            recv;
        logic [P*DW-1:0] rdata;
    } stat_t;

    send_t send_q[$];
    stat_t stat_q[$];

    // Reference model: per-port request records, a queue of in-flight read owners.
    logic [P-1:0]   m_pend = '0, m_write = '0, m_infl = '0;
    logic [AW-1:0]  m_addr [P];
    logic [DW-1:0]  m_data [P];
    logic [DWB-1:0] m_mask [P];
    logic [DW-1:0]  m_rdata [P];
    int             m_rr = P - 1;
    int             m_tags[$];
    logic           m_unexp = 1'b0;

    always @(posedge CLK) begin
        stat_t        s;
        send_t        sq;
        int           g, q, p;
        logic [P-1:0] pend_pre;
        logic [1:0]   f;
        cyc++;
        s.done = '0;
        s.recv = 1'b0;
        if (RST) begin
            m_pend = '0;
            m_infl = '0;
            m_rr = P - 1;
            m_tags.delete();
            m_unexp = 1'b0;
            for (int i = 0; i < P; i++) m_rdata[i] = '0;
        end else begin
            pend_pre = m_pend;
            g = -1;
            if (sendable) begin
                for (int k = 1; k <= P; k++) begin
                    q = (m_rr + k) % P;
                    if (g < 0 && m_pend[q] && !m_infl[q] && (m_write[q] || m_tags.size() < MAXO)) g = q;
                end
            end
            if (receivable) begin
                if (m_tags.size() > 0) begin
                    p = m_tags.pop_front();
                    m_rdata[p] = recv_data[DW-1:0];
                    m_pend[p] = 1'b0;
                    m_infl[p] = 1'b0;
                    s.done[p] = 1'b1;
                    s.recv = 1'b1;
                end else begin
                    m_unexp = 1'b1;
                end
            end
            if (g >= 0) begin
                m_rr = g;
                sq.cyc = cyc;
                if (m_write[g]) begin
                    sq.data = {8'h80 | 8'(m_mask[g]), m_addr[g], m_data[g]};
                    sq.len = 5'(SB);
                    m_pend[g] = 1'b0;
                    s.done[g] = 1'b1;
                end else begin
                    sq.data = SW'(m_addr[g]);
                    sq.len = 5'(AWB + 1);
                    m_infl[g] = 1'b1;
                    m_tags.push_back(g);
                end
                send_q.push_back(sq);
            end
            for (int i = 0; i < P; i++) begin
                f = rw_flag_[2*i +: 2];
                if (!pend_pre[i] && (f == 2'd1 || f == 2'd2)) begin
                    m_pend[i] = 1'b1;
                    m_write[i] = (f == 2'd2);
                    m_infl[i] = 1'b0;
                    m_addr[i] = addr_[AW*i +: AW];
                    m_data[i] = write_data_[DW*i +: DW];
                    m_mask[i] = write_mask_[DWB*i +: DWB];
                end
            end
        end
        for (int i = 0; i < P; i++) s.rdata[DW*i +: DW] = m_rdata[i];
        s.busy = m_pend;
        s.outst = OW'(m_tags.size());
        s.unexp = m_unexp;
        stat_q.push_back(s);
    end

    // Monitor: compares DUT outputs against the scoreboard queues each falling edge.
    always @(negedge CLK) begin
        stat_t s;
        send_t e;
        logic  exp_send;
        if (cyc > 0) begin
            exp_send = (send_q.size() > 0) && (send_q[0].cyc == cyc);
            if (send_flag || exp_send) begin
                check("send_flag", 256'(send_flag), 256'(exp_send));
                if (exp_send) begin
                    e = send_q.pop_front();
                    if (send_flag) begin
                        check("send_data", 256'(send_data), 256'(e.data));
                        check("send_length", 256'(send_length), 256'(e.len));
                    end
                end
            end
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("busy", 256'(busy), 256'(s.busy));
                check("outstanding", 256'(outstanding), 256'(s.outst));
                check("unexpected_recv", 256'(unexpected_recv), 256'(s.unexp));
                check("read_data", 256'(read_data_), 256'(s.rdata));
                if (done != '0 || recv_flag || s.done != '0 || s.recv) begin
                    check("done", 256'(done), 256'(s.done));
                    check("recv_flag", 256'(recv_flag), 256'(s.recv));
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic req(input int p, input logic [1:0] f, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DWB-1:0] m);
        rw_flag_[2*p +: 2]     = f;
        addr_[AW*p +: AW]      = a;
        write_data_[DW*p +: DW] = d;
        write_mask_[DWB*p +: DWB] = m;
    endtask

    task automatic wait_send(output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (send_flag) seen = 1'b1;
        end
        check("wait_send_timeout", 256'(seen), 256'(1));
    endtask

    initial begin
        int n;
        repeat (3) tick();
        RST = 1'b0;
        check("rst_send_flag", 256'(send_flag), 256'(0));
        check("rst_send_data", 256'(send_data), 256'(0));
        check("rst_send_length", 256'(send_length), 256'(0));
        check("rst_recv_flag", 256'(recv_flag), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_outstanding", 256'(outstanding), 256'(0));
        check("rst_unexpected", 256'(unexpected_recv), 256'(0));
        check("rst_read_data", 256'(read_data_), 256'(0));

        // Basic read on port 0.
        sendable = 1'b1;
        req(0, 2'd1, 32'h100, '0, '0);
        tick();
        req(0, 2'd0, 32'h100, '0, '0);
        wait_send(n);
        check("read_latency", 256'(n), 256'(1));
        check("read_pkt", 256'(send_data), 256'(72'h00_00000000_00000100));
        check("read_len", 256'(send_length), 256'(5));
        receivable = 1'b1;
        recv_data = 72'hAB_CDEF0123_DEADBEEF;
        tick();
        receivable = 1'b0;
        check("resp_recv_flag", 256'(recv_flag), 256'(1));
        check("resp_done", 256'(done), 256'(4'b0001));
        check("resp_read_data0", 256'(read_data_[DW-1:0]), 256'(32'hDEADBEEF));
        check("resp_busy", 256'(busy), 256'(0));

        // Outstanding cap: three reads, two slots; a write still issues.
        req(0, 2'd1, 32'h10, '0, '0);
        req(1, 2'd1, 32'h20, '0, '0);
        req(2, 2'd1, 32'h30, '0, '0);
        tick();
        rw_flag_ = '0;
        repeat (5) tick();
        check("cap_outstanding", 256'(outstanding), 256'(2));
        check("cap_busy", 256'(busy), 256'(4'b0111));
        req(3, 2'd2, 32'h40, 32'h1234, 4'b0011);
        tick();
        rw_flag_ = '0;
        wait_send(n);
        check("write_pkt", 256'(send_data), 256'({8'h83, 32'h40, 32'h1234}));
        check("write_len", 256'(send_length), 256'(9));
        check("write_done", 256'(done), 256'(4'b1000));
        receivable = 1'b1;
        recv_data = 72'hA;
        tick();
        receivable = 1'b0;
        check("order_port1", 256'(read_data_[DW*1 +: DW]), 256'(32'hA));
        wait_send(n);
        check("third_read_pkt", 256'(send_data), 256'(72'h10));
        receivable = 1'b1;
        recv_data = 72'hB;
        tick();
        check("order_port2", 256'(read_data_[DW*2 +: DW]), 256'(32'hB));
        recv_data = 72'hC;
        tick();
        receivable = 1'b0;
        check("order_port0", 256'(read_data_[DW*0 +: DW]), 256'(32'hC));
        check("drained_outstanding", 256'(outstanding), 256'(0));

        // Stray response with nothing in flight.
        receivable = 1'b1;
        tick();
        receivable = 1'b0;
        check("stray_recv_flag", 256'(recv_flag), 256'(0));
        check("stray_unexpected", 256'(unexpected_recv), 256'(1));
        repeat (3) tick();
        check("stray_sticky", 256'(unexpected_recv), 256'(1));

        // Reset with two reads in flight.
        req(0, 2'd1, 32'h50, '0, '0);
        req(1, 2'd1, 32'h60, '0, '0);
        tick();
        rw_flag_ = '0;
        repeat (4) tick();
        check("pre_rst_outstanding", 256'(outstanding), 256'(2));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_outstanding", 256'(outstanding), 256'(0));
        check("mid_rst_unexpected", 256'(unexpected_recv), 256'(0));
        repeat (3) tick();
        check("mid_rst_no_done", 256'(done), 256'(0));
        receivable = 1'b1;
        tick();
        receivable = 1'b0;
        check("post_rst_unexpected", 256'(unexpected_recv), 256'(1));
        check("post_rst_recv_flag", 256'(recv_flag), 256'(0));

        // Randomized traffic, checked entirely by the monitor.
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 249) == 0);
            sendable = ($urandom_range(0, 3) != 0);
            receivable = ($urandom_range(0, 2) == 0);
            recv_data = {$urandom, $urandom, $urandom};
            for (int p = 0; p < P; p++) begin
                req(p, $urandom_range(0, 1) ? 2'($urandom_range(0, 3)) : 2'd0,
                    $urandom, $urandom, 4'($urandom));
            end
            tick();
        end
        RST = 1'b0;
        rw_flag_ = '0;
        sendable = 1'b1;
        receivable = 1'b1;
        repeat (20) tick();
        receivable = 1'b0;
        tick();
        check("send_queue_drained", 256'(send_q.size()), 256'(0));
        check("final_outstanding", 256'(outstanding), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
